// File: rtl/sram_multiport_ctrl.sv
// Multi-port arbiter and controller for an asynchronous external SRAM.
// Serialises requests onto the SRAM pins, with wait states set at elaboration.
module sram_multiport_ctrl #(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3,
    parameter int RD_WAIT   = 2,
    parameter int WR_WAIT   = 2,
    parameter int ARB_MODE  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           SRAM_ADDR,
    inout  wire  [DATA_W-1:0]           SRAM_DATA,
    output logic                        SRAM_WE_n
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if ((RD_WAIT < 1) || (RD_WAIT > 15) || (WR_WAIT < 1) || (WR_WAIT > 15)) begin : g_wait_range_err
        $error("sram_multiport_ctrl: RD_WAIT and WR_WAIT must be within 1..15");
    end
    if ((NUM_PORTS < 1) || (NUM_PORTS > 8)) begin : g_ports_range_err
        $error("sram_multiport_ctrl: NUM_PORTS must be within 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PW-1:0]       last_grant_r;
    logic [PW-1:0]       grant_r;
    logic [PW-1:0]       grant_s;
    logic [PW-1:0]       idx_s;
    logic                any_req_s;
    logic                we_r;
    logic                drive_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [3:0]          cnt_r;
    logic [ADDR_W-1:0]   addr_a_s  [NUM_PORTS];
    logic [DATA_W-1:0]   wdata_a_s [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_a_s[p]  = addr[p*ADDR_W +: ADDR_W];
        assign wdata_a_s[p] = wdata[p*DATA_W +: DATA_W];
    end

    assign SRAM_DATA = drive_r ? wdata_r : {DATA_W{1'bz}};

    // Winner selection: scanning from lowest to highest priority, the last hit wins.
    always_comb begin
        grant_s   = {PW{1'b0}};
        idx_s     = {PW{1'b0}};
        any_req_s = |req;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (ARB_MODE == 1) begin
                idx_s = PW'(i - 1);
            end else begin
                idx_s = PW'((int'(last_grant_r) + i) % NUM_PORTS);
            end
            if (req[idx_s]) begin
                grant_s = idx_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered datapath and pin drivers; reset aborts an access with no ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= PW'(NUM_PORTS - 1);
            grant_r      <= {PW{1'b0}};
            we_r         <= 1'b0;
            drive_r      <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            cnt_r        <= 4'd0;
            ack          <= {NUM_PORTS{1'b0}};
            rdata        <= {DATA_W{1'b0}};
            busy         <= 1'b0;
            SRAM_ADDR    <= {ADDR_W{1'b0}};
            SRAM_WE_n    <= 1'b1;
        end else begin
            ack <= {NUM_PORTS{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r      <= grant_s;
                        last_grant_r <= grant_s;
                        we_r         <= we[grant_s];
                        drive_r      <= we[grant_s];
                        wdata_r      <= wdata_a_s[grant_s];
                        SRAM_ADDR    <= addr_a_s[grant_s];
                        busy         <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    cnt_r     <= we_r ? 4'(WR_WAIT) : 4'(RD_WAIT);
                    SRAM_WE_n <= ~we_r;
                end
                ST_ACCESS: begin
                    if (cnt_r == 4'd1) begin
                        SRAM_WE_n    <= 1'b1;
                        ack[grant_r] <= 1'b1;
                        if (!we_r) begin
                            rdata <= SRAM_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    drive_r <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    drive_r   <= 1'b0;
                    SRAM_WE_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
